// File: rtl/serial_mag_comparator_lsb.sv
`default_nettype none
// ============================================================================
// serial_mag_comparator_lsb : LSB-first bit-serial magnitude comparator
// Rev 1.0
// ============================================================================
module serial_mag_comparator_lsb #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         Start,
  input  logic                         BitValid,
  input  logic                         A,
  input  logic                         B,
  output logic                         Busy,
  output logic                         Done,
  output logic                         ResultValid,
  output logic                         Lt,
  output logic                         Gt,
  output logic                         Eq,
  output logic [$clog2(WIDTH+1)-1:0]   BitCount
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam bit              SIGNED_B = (SIGNED != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             lt_acc_q, lt_acc_d;
  logic             gt_acc_q, gt_acc_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             result_valid_q, result_valid_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;

  logic             last_bit;
  logic             bit_lt;
  logic             bit_gt;
  logic             lt_next;
  logic             gt_next;

  always_comb begin
    last_bit = (bit_count_q == LAST_IDX);
    // The sign bit carries negative weight, so its sense is reversed.
    if (SIGNED_B && last_bit) begin
      bit_lt = A & ~B;
      bit_gt = ~A & B;
    end else begin
      bit_lt = ~A & B;
      bit_gt = A & ~B;
    end
    lt_next = (A != B) ? bit_lt : lt_acc_q;
    gt_next = (A != B) ? bit_gt : gt_acc_q;

    state_d        = state_q;
    lt_acc_d       = lt_acc_q;
    gt_acc_d       = gt_acc_q;
    bit_count_d    = bit_count_q;
    done_d         = 1'b0;
    result_valid_d = result_valid_q;
    lt_d           = lt_q;
    gt_d           = gt_q;
    eq_d           = eq_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d        = ST_RUN;
          bit_count_d    = '0;
          lt_acc_d       = 1'b0;
          gt_acc_d       = 1'b0;
          result_valid_d = 1'b0;
          lt_d           = 1'b0;
          gt_d           = 1'b0;
          eq_d           = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (Start) begin
          bit_count_d = '0;
          lt_acc_d    = 1'b0;
          gt_acc_d    = 1'b0;
        end else if (BitValid) begin
          bit_count_d = bit_count_q + 1'b1;
          lt_acc_d    = lt_next;
          gt_acc_d    = gt_next;
          if (last_bit) begin
            state_d        = ST_DONE;
            done_d         = 1'b1;
            result_valid_d = 1'b1;
            lt_d           = lt_next;
            gt_d           = gt_next;
            eq_d           = ~lt_next & ~gt_next;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q        <= ST_IDLE;
      lt_acc_q       <= 1'b0;
      gt_acc_q       <= 1'b0;
      bit_count_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
      lt_q           <= 1'b0;
      gt_q           <= 1'b0;
      eq_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      lt_acc_q       <= lt_acc_d;
      gt_acc_q       <= gt_acc_d;
      bit_count_q    <= bit_count_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      result_valid_q <= result_valid_d;
      lt_q           <= lt_d;
      gt_q           <= gt_d;
      eq_q           <= eq_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign ResultValid = result_valid_q;
  assign Lt          = lt_q;
  assign Gt          = gt_q;
  assign Eq          = eq_q;
  assign BitCount    = bit_count_q;

endmodule
`default_nettype wire
